timer_bank: RTL
===============

Name: timer_bank

Overview:
- N-channel programmable timer bank; the parametrised successor to the single-channel alarm/timeout/pulse/strobe timers.
- Each channel has a per-channel mode and a W-bit count; one shared prescaler drives all channels.
- Lives under timer/ and is used by controllers that need several independent timeouts/periodic strobes without instantiating one timer per event.

Parameters:
- W, 8, width of count value and prescaler.
- N, 4, number of channels (1..16).
- SW, $clog2(N) (min 1), width of channel select; derived, not overridden.

Ports:
- clock  in  1  system clock, all state changes on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- prescale  in  W  tick divider; one tick every prescale+1 clocks.
- sel  in  SW  channel addressed by put.
- mode  in  2  mode written on put (0 ALARM, 1 TIMEOUT, 2 PULSE, 3 STROBE).
- value  in  W  count written on put, in ticks.
- put  in  1  load strobe, one clock wide per write.
- fire  out  N  per-channel output, meaning per mode.
- busy  out  N  channel counting (state RUN).

Behaviour:
- Reset (reset==0 at edge): prescaler counter=0; all channels IDLE, cnt=0, mode=ALARM; fire=0, busy=0. Reset mid-count discards everything; no fire pulse is emitted.
- Prescaler: pcnt free-running. tick=1 when pcnt>=prescale, and pcnt then returns to 0; else pcnt+1. The >= comparison ensures lowering prescale mid-run never wraps. prescale=0 gives a tick every clock. put does not resync the prescaler, so the first tick after a put comes 1..prescale+1 clocks later.
- Channel states: IDLE, RUN, DONE (DONE is used only by TIMEOUT).
- put with sel<N, value!=0: channel loads cnt=value and mode, enters RUN; busy=1 next clock.
- put with value==0: channel goes IDLE, fire=0 (cancel).
- put with sel>=N: ignored.
- RUN, on tick: if cnt==1, the channel expires; else cnt=cnt-1. Expiry happens on the value-th tick after the load.
- Expiry by mode:
  - ALARM: fire=1 for exactly one clock, then IDLE.
  - TIMEOUT: enter DONE; fire held 1 until the next put to that channel or reset.
  - PULSE: fire=1 throughout RUN (from the clock after put); drops to 0 on expiry, then IDLE.
  - STROBE: one-clock fire pulse, cnt reloaded from the stored value, stays RUN (periodic, period value ticks).
- All outputs are registered. With prescale=0, put at edge k gives an ALARM pulse after edge k+value and busy falling after the same edge.
- Simultaneous put and expiry on the same channel: put wins; no fire pulse; new count loaded.
- Simultaneous put and tick on the same channel: tick ignored for that channel that clock.
- put to one channel never disturbs the others.
- The STROBE period uses the value stored at the last put, not the live input.
- W-bit unsigned arithmetic throughout; cnt never underflows because the ==1 check precedes the decrement.

Decomposition:
- Package timer_pkg: mode constants TIMER_ALARM=2'd0, TIMER_TIMEOUT=2'd1, TIMER_PULSE=2'd2, TIMER_STROBE=2'd3; state encodings IDLE/RUN/DONE.
- Sub-module timer_channel, holding one channel's state, cnt, stored value, mode and fire/busy registers. Inputs: clock, reset, tick, load, mode, value.
- timer_bank holds the prescaler and the sel decode, and generates N timer_channel instances.

Test Plan:
- Reset and prescale=0: hold reset=0 3 clocks -> fire=0, busy=0. Then put ch0 ALARM value=5 at edge k -> fire[0] one-clock pulse after edge k+5, busy[0] high edges k+1..k+5.
- STROBE periodic: prescale=0, put ch1 STROBE value=3 -> fire[1] pulses every 3 clocks, at least 4 periods. Then put ch1 value=0 -> no further pulses, busy[1]=0.
- TIMEOUT and PULSE: prescale=0, TIMEOUT ch2 value=4 -> fire[2] rises after 4 clocks and stays high until the next put. PULSE ch3 value=4 -> fire[3] high for exactly 4 clocks starting the clock after put.
- Prescaler: prescale=4, ALARM value=2 -> fire between 6 and 10 clocks after put. Change prescale 4->1 mid-run -> next tick within 2 clocks, no stall.
- Collisions: put ch0 on the exact clock its ALARM expires -> no pulse, new count runs. put with sel=N (N=3 build) -> no channel changes.
- Reset mid-operation: all four channels running, reset=0 one clock -> all fire/busy 0 next clock, no pulses afterward until a new put.

Source files
------------

// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared mode constants and channel state encoding for the timer bank
package timer_pkg;

  localparam logic [1:0] TIMER_ALARM   = 2'd0;
  localparam logic [1:0] TIMER_TIMEOUT = 2'd1;
  localparam logic [1:0] TIMER_PULSE   = 2'd2;
  localparam logic [1:0] TIMER_STROBE  = 2'd3;

  // DONE is only reached by TIMEOUT channels, which park there with fire held.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } timer_state_e;

endpackage

// File: rtl/timer_channel.sv
// rtl/timer_channel.sv - one timer channel: state, down-counter, stored reload value, registered fire/busy
module timer_channel
  import timer_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         tick,
  input  logic         load,
  input  logic [1:0]   mode,
  input  logic [W-1:0] value,
  output logic         fire,
  output logic         busy
);

  timer_state_e state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] val_q, val_d;
  logic [1:0]   mode_q, mode_d;
  logic         fire_q, fire_d;
  logic         busy_q, busy_d;
  logic         expire;

  assign expire = (state_q == ST_RUN) && tick && (cnt_q == W'(1));

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      val_q   <= '0;
      mode_q  <= TIMER_ALARM;
      fire_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      mode_q  <= mode_d;
      fire_q  <= fire_d;
      busy_q  <= busy_d;
    end
  end

  // A load takes priority over any tick or expiry arriving on the same clock.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    val_d   = val_q;
    mode_d  = mode_q;
    if (load) begin
      if (value != '0) begin
        state_d = ST_RUN;
        cnt_d   = value;
        val_d   = value;
        mode_d  = mode;
      end else begin
        state_d = ST_IDLE;
      end
    end else if ((state_q == ST_RUN) && tick) begin
      if (cnt_q == W'(1)) begin
        case (mode_q)
          TIMER_TIMEOUT: state_d = ST_DONE;
          TIMER_STROBE:  cnt_d   = val_q;
          default:       state_d = ST_IDLE;
        endcase
      end else begin
        cnt_d = cnt_q - W'(1);
      end
    end
  end

  always_comb begin
    fire_d = (state_q == ST_DONE) || ((state_q == ST_RUN) && (mode_q == TIMER_PULSE));
    if (load) begin
      fire_d = (value != '0) && (mode == TIMER_PULSE);
    end else if (expire) begin
      fire_d = (mode_q != TIMER_PULSE);
    end
    busy_d = (state_d == ST_RUN);
  end

  assign fire = fire_q;
  assign busy = busy_q;

endmodule

// File: rtl/timer_bank.sv
// rtl/timer_bank.sv - N-channel timer bank with a shared prescaler and per-channel load decode
module timer_bank
  import timer_pkg::*;
#(
  parameter  int W  = 8,
  parameter  int N  = 4,
  localparam int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [W-1:0]  prescale,
  input  logic [SW-1:0] sel,
  input  logic [1:0]    mode,
  input  logic [W-1:0]  value,
  input  logic          put,
  output logic [N-1:0]  fire,
  output logic [N-1:0]  busy
);

  logic [W-1:0] pcnt_q, pcnt_d;
  logic         tick;

  // >= rather than == so lowering prescale below the running count ticks at once.
  assign tick   = (pcnt_q >= prescale);
  assign pcnt_d = tick ? '0 : pcnt_q + W'(1);

  always_ff @(posedge clock) begin
    if (!reset) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic load;
    assign load = put && (sel == SW'(i));

    timer_channel #(.W(W)) u_ch (
      .clock (clock),
      .reset (reset),
      .tick  (tick),
      .load  (load),
      .mode  (mode),
      .value (value),
      .fire  (fire[i]),
      .busy  (busy[i])
    );
  end

endmodule
